// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM port-A arbiter: funct3 codes, FSM encoding, master-id width.
// The optional alignment checker is enabled with RAM_ARB_ALIGN_CHECK_EN (see ram_port_arbiter).
package ram_arb_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int MID_W = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  // Stores only have byte/half/word encodings; 011/110/111 are reserved for loads too.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic wr);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (wr && f3[2]);
  endfunction

endpackage

// File: rtl/ram_load_align.sv
// Combinational load extractor: picks the byte/half/word addressed by off out of a RAM word
// and sign- or zero-extends it according to funct3. Also used by the CPU core.
module ram_load_align
  import ram_arb_pkg::*;
(
  input  logic [31:0] i_dout,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_off)
      2'd0:    w_byte = i_dout[7:0];
      2'd1:    w_byte = i_dout[15:8];
      2'd2:    w_byte = i_dout[23:16];
      default: w_byte = i_dout[31:24];
    endcase
  end

  assign w_half = i_off[1] ? i_dout[31:16] : i_dout[15:0];

  always_comb begin
    o_data = i_dout;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_data = {24'h0, w_byte};
      F3_LHU:  o_data = {16'h0, w_half};
      default: o_data = i_dout;
    endcase
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin two-master sequencer for RAM port A: IDLE (accept) -> ACCESS (drive RAM) -> RESPOND.
// Define RAM_ARB_ALIGN_CHECK_EN to flag misaligned/illegal accesses instead of force-aligning them.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  m_valid,
  output logic [1:0]                  m_ready,
  input  logic [2*(ADDR_WIDTH+2)-1:0] m_addr,
  input  logic [1:0]                  m_write,
  input  logic [5:0]                  m_funct3,
  input  logic [63:0]                 m_wdata,
  output logic [1:0]                  rsp_valid,
  output logic [31:0]                 rsp_rdata,
  output logic                        rsp_err,
  output logic                        ram_en,
  output logic [3:0]                  ram_we,
  output logic [ADDR_WIDTH-1:0]       ram_addr,
  output logic [31:0]                 ram_din,
  input  logic [31:0]                 ram_dout
);

  localparam int BW = ADDR_WIDTH + 2;

  state_t                  r_state;
  logic [MID_W-1:0]        r_id;
  logic [MID_W-1:0]        r_last_grant;
  logic [1:0]              r_off;
  logic [2:0]              r_f3;
  logic                    r_write;
  logic                    r_err_pend;
  logic                    r_rsp_err;
  logic [1:0]              r_rsp_valid;
  logic                    r_ram_en;
  logic [3:0]              r_ram_we;
  logic [ADDR_WIDTH-1:0]   r_ram_addr;
  logic [31:0]             r_ram_din;

  logic [MID_W-1:0]        w_gnt_id;
  logic                    w_accept;
  logic [BW-1:0]           w_addr;
  logic                    w_wr;
  logic [2:0]              w_f3;
  logic [2:0]              w_f3_eff;
  logic [31:0]             w_wdata;
  logic [1:0]              w_off;
  logic [1:0]              w_off_eff;
  logic                    w_err;
  logic [3:0]              w_we;
  logic [31:0]             w_load;

  always_comb begin
    w_gnt_id = 1'b0;
    if (m_valid == 2'b11) w_gnt_id = ~r_last_grant;
    else if (m_valid[1])  w_gnt_id = 1'b1;
  end

  assign w_accept = (r_state == ST_IDLE) && !rst && (m_valid != 2'b00);
  assign m_ready  = w_accept ? (2'b01 << w_gnt_id) : 2'b00;

  assign w_addr  = w_gnt_id ? m_addr[2*BW-1:BW] : m_addr[BW-1:0];
  assign w_wr    = m_write[w_gnt_id];
  assign w_f3    = w_gnt_id ? m_funct3[5:3] : m_funct3[2:0];
  assign w_wdata = w_gnt_id ? m_wdata[63:32] : m_wdata[31:0];
  assign w_off   = w_addr[1:0];

`ifdef RAM_ARB_ALIGN_CHECK_EN
  assign w_f3_eff  = w_f3;
  assign w_off_eff = w_off;
  assign w_err     = f3_illegal(w_f3, w_wr)
                   || ((w_f3[1:0] == 2'b01) && w_off[0])
                   || ((w_f3[1:0] == 2'b10) && (w_off != 2'b00));
`else
  // Without checking, illegal codes become word accesses and offsets are rounded down.
  assign w_f3_eff  = f3_illegal(w_f3, w_wr) ? F3_LW : w_f3;
  assign w_off_eff = (w_f3_eff[1:0] == 2'b01) ? {w_off[1], 1'b0} :
                     (w_f3_eff[1:0] == 2'b10) ? 2'b00 : w_off;
  assign w_err     = 1'b0;
`endif

  always_comb begin
    w_we = 4'b0000;
    if (w_wr && !w_err) begin
      case (w_f3_eff[1:0])
        2'b00:   w_we = 4'b0001 << w_off_eff;
        2'b01:   w_we = 4'b0011 << w_off_eff;
        default: w_we = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_id         <= '0;
      r_last_grant <= 1'b1;
      r_off        <= 2'b00;
      r_f3         <= 3'b000;
      r_write      <= 1'b0;
      r_err_pend   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_valid  <= 2'b00;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 4'b0000;
      r_ram_addr   <= '0;
      r_ram_din    <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rsp_valid <= 2'b00;
          r_rsp_err   <= 1'b0;
          if (w_accept) begin
            r_id         <= w_gnt_id;
            r_last_grant <= w_gnt_id;
            r_off        <= w_off_eff;
            r_f3         <= w_f3_eff;
            r_write      <= w_wr;
            r_err_pend   <= w_err;
            r_ram_en     <= !w_err;
            r_ram_we     <= w_we;
            r_ram_addr   <= w_addr[BW-1:2];
            r_ram_din    <= w_wdata << {w_off_eff, 3'b000};
            r_state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_ram_en    <= 1'b0;
          r_ram_we    <= 4'b0000;
          r_rsp_valid <= 2'b01 << r_id;
          r_rsp_err   <= r_err_pend;
          r_state     <= ST_RESPOND;
        end
        default: begin
          r_rsp_valid <= 2'b00;
          r_rsp_err   <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM read data only exists in RESPOND, so the load result is formed combinationally there.
  ram_load_align u_load_align (
    .i_dout   (ram_dout),
    .i_off    (r_off),
    .i_funct3 (r_f3),
    .o_data   (w_load)
  );

  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_din   = r_ram_din;
  assign rsp_valid = rst ? 2'b00 : r_rsp_valid;
  assign rsp_err   = r_rsp_err && !rst;
  assign rsp_rdata = ((r_rsp_valid != 2'b00) && !rst && !r_write && !r_rsp_err) ? w_load : 32'h0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural byte-lane RAM on port A.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  m_valid = 2'b00;
  logic [1:0]  m_ready;
  logic [27:0] m_addr = '0;
  logic [1:0]  m_write = 2'b00;
  logic [5:0]  m_funct3 = '0;
  logic [63:0] m_wdata = '0;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout = 32'h0;

  logic [31:0] mem [0:4095];
  int n_tests = 0;
  int n_fail  = 0;

  ram_port_arbiter #(.ADDR_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
    .m_write(m_write), .m_funct3(m_funct3), .m_wdata(m_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [13:0] a, input logic wr,
                         input logic [2:0] f3, input logic [31:0] wd);
    m_addr[id*14 +: 14]  = a;
    m_write[id]          = wr;
    m_funct3[id*3 +: 3]  = f3;
    m_wdata[id*32 +: 32] = wd;
  endtask

  // One transaction from accept to response, checking the RAM side and the response side.
  task automatic xact(input string name, input int id, input logic [13:0] a, input logic wr,
                      input logic [2:0] f3, input logic [31:0] wd,
                      input logic exp_en, input logic [3:0] exp_we, input logic [31:0] exp_din,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int w;
    @(negedge clk);
    set_req(id, a, wr, f3, wd);
    m_valid[id] = 1'b1;
    #1;
    w = 0;
    while (!m_ready[id] && w < 10) begin @(negedge clk); #1; w++; end
    check({name, ".ready"}, {30'h0, m_ready}, 32'h1 << id);
    @(negedge clk);
    m_valid[id] = 1'b0;
    #1;
    check({name, ".en"},   {31'h0, ram_en}, {31'h0, exp_en});
    check({name, ".we"},   {28'h0, ram_we}, {28'h0, exp_we});
    check({name, ".addr"}, {20'h0, ram_addr}, {20'h0, a[13:2]});
    check({name, ".din"},  ram_din, exp_din);
    @(negedge clk);
    #1;
    check({name, ".rspv"},  {30'h0, rsp_valid}, 32'h1 << id);
    check({name, ".rdata"}, rsp_rdata, exp_rdata);
    check({name, ".err"},   {31'h0, rsp_err}, {31'h0, exp_err});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int exp_id;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;

    repeat (3) @(negedge clk);
    #1;
    check("rst.ready", {30'h0, m_ready}, 32'h0);
    check("rst.rspv",  {30'h0, rsp_valid}, 32'h0);
    check("rst.rdata", rsp_rdata, 32'h0);
    check("rst.err",   {31'h0, rsp_err}, 32'h0);
    check("rst.en",    {31'h0, ram_en}, 32'h0);
    check("rst.we",    {28'h0, ram_we}, 32'h0);
    check("rst.addr",  {20'h0, ram_addr}, 32'h0);
    check("rst.din",   ram_din, 32'h0);
    rst = 1'b0;

    xact("sw010", 0, 14'h010, 1'b1, 3'b010, 32'hDEADBEEF, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("lw010", 0, 14'h010, 1'b0, 3'b010, 32'h0, 1'b1, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0);
    xact("sb013", 0, 14'h013, 1'b1, 3'b000, 32'h00000080, 1'b1, 4'b1000, 32'h80000000, 32'h0, 1'b0);
    xact("lb013", 0, 14'h013, 1'b0, 3'b000, 32'h0, 1'b1, 4'b0000, 32'h0, 32'hFFFFFF80, 1'b0);
    xact("lbu013", 0, 14'h013, 1'b0, 3'b100, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h00000080, 1'b0);
    xact("lw010b", 0, 14'h010, 1'b0, 3'b010, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h80ADBEEF, 1'b0);
`ifdef RAM_ARB_ALIGN_CHECK_EN
    xact("lh011", 0, 14'h011, 1'b0, 3'b001, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
`else
    xact("lh011", 0, 14'h011, 1'b0, 3'b001, 32'h0, 1'b1, 4'b0000, 32'h0, 32'hFFFFBEEF, 1'b0);
`endif
    xact("lhu012", 0, 14'h012, 1'b0, 3'b101, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h000080AD, 1'b0);
    xact("sh016", 1, 14'h016, 1'b1, 3'b001, 32'h0000CAFE, 1'b1, 4'b1100, 32'hCAFE0000, 32'h0, 1'b0);
    xact("lw014", 1, 14'h014, 1'b0, 3'b010, 32'h0, 1'b1, 4'b0000, 32'h0, 32'hCAFE0000, 1'b0);

    // Reset during ACCESS of a store: write lands, response never appears.
    @(negedge clk);
    set_req(0, 14'h020, 1'b1, 3'b010, 32'h12345678);
    m_valid = 2'b01;
    #1;
    check("rsta.ready", {30'h0, m_ready}, 32'h1);
    @(negedge clk);
    m_valid = 2'b00;
    #1;
    check("rsta.we", {28'h0, ram_we}, 32'hF);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rsta.rspv0", {30'h0, rsp_valid}, 32'h0);
    check("rsta.en",    {31'h0, ram_en}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rsta.rspv1", {30'h0, rsp_valid}, 32'h0);

    // Both masters always valid: grants alternate starting with master 0.
    set_req(0, 14'h010, 1'b0, 3'b010, 32'h0);
    set_req(1, 14'h020, 1'b0, 3'b010, 32'h0);
    m_valid = 2'b11;
    exp_id = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      w = 0;
      while (m_ready == 2'b00 && w < 10) begin @(negedge clk); #1; w++; end
      check("rr.wait",  w, 0);
      check("rr.grant", {30'h0, m_ready}, 32'h1 << exp_id);
      @(negedge clk);
      #1;
      check("rr.gap", {30'h0, m_ready}, 32'h0);
      @(negedge clk);
      #1;
      check("rr.rspv",  {30'h0, rsp_valid}, 32'h1 << exp_id);
      check("rr.rdata", rsp_rdata, (exp_id == 0) ? 32'h80ADBEEF : 32'h12345678);
      @(negedge clk);
      exp_id = 1 - exp_id;
    end
    m_valid = 2'b00;

    // Master 1 alone, back-to-back: accepted every third cycle.
    set_req(1, 14'h014, 1'b0, 3'b010, 32'h0);
    m_valid = 2'b10;
    for (int k = 0; k < 4; k++) begin
      #1;
      w = 0;
      while (m_ready == 2'b00 && w < 10) begin @(negedge clk); #1; w++; end
      check("m1.wait",  w, 0);
      check("m1.grant", {30'h0, m_ready}, 32'h2);
      @(negedge clk);
      @(negedge clk);
      #1;
      check("m1.rspv",  {30'h0, rsp_valid}, 32'h2);
      check("m1.rdata", rsp_rdata, 32'hCAFE0000);
      @(negedge clk);
    end
    m_valid = 2'b00;

    // Reset during RESPOND suppresses the pulse.
    @(negedge clk);
    set_req(0, 14'h010, 1'b0, 3'b010, 32'h0);
    m_valid = 2'b01;
    #1;
    check("rstr.ready", {30'h0, m_ready}, 32'h1);
    @(negedge clk);
    m_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstr.rspv",  {30'h0, rsp_valid}, 32'h0);
    check("rstr.rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstr.rspv1", {30'h0, rsp_valid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
